// File: rtl/term_pkg.sv
// rtl/term_pkg.sv - shared register map, FSM encoding and character constants for the terminal port
package term_pkg;

  localparam int COLS_DEF = 80;
  localparam int ROWS_DEF = 30;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_CURSOR = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  localparam logic [7:0] CH_BLANK = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    CLEAR,
    DONE
  } state_t;

endpackage

// File: rtl/term_cursor.sv
// rtl/term_cursor.sv - cursor arithmetic: advance with wrap, row start, next row, load clamp
module term_cursor import term_pkg::*; #(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic [11:0] cursor,
  input  logic [11:0] load_val,
  output logic [11:0] advance,
  output logic [11:0] row_start,
  output logic [11:0] next_row,
  output logic [11:0] load_clamped
);

  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [11:0] CELLS_W  = 12'(COLS * ROWS);
  localparam logic [11:0] CELLS_M1 = 12'(COLS * ROWS - 1);

  logic [11:0] row_idx;
  logic [12:0] nxt_sum;

  // All cursor positions derived from the current cell index; the last cell and last row wrap to 0
  always_comb begin
    advance      = (cursor == CELLS_M1) ? 12'd0 : cursor + 12'd1;
    row_idx      = cursor / COLS_W;
    row_start    = row_idx * COLS_W;
    nxt_sum      = {1'b0, row_start} + {1'b0, COLS_W};
    next_row     = (nxt_sum >= {1'b0, CELLS_W}) ? 12'd0 : nxt_sum[11:0];
    load_clamped = (load_val >= CELLS_W) ? 12'd0 : load_val;
  end

endmodule

// File: rtl/term_bus_port.sv
// rtl/term_bus_port.sv - CPU register port onto terminal text RAM (option: TERM_PORT_CTRLCHAR_EN)
module term_bus_port import term_pkg::*; #(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [11:0] text_addr,
  output logic        text_write,
  output logic [7:0]  text_in,
  input  logic [7:0]  text_out
);

  localparam logic [11:0] CELLS_M1 = 12'(COLS * ROWS - 1);

  state_t      state, state_d;
  logic [11:0] cursor;
  logic [11:0] clr_cnt;
  logic [7:0]  wdata_q;
  logic        ctl_q;
  logic [31:0] rdata_q;
  logic        busy;
  logic        is_ctl;

  logic [11:0] cur_advance, cur_row_start, cur_next_row, cur_load;
  logic        unused_bits;

  assign unused_bits = &{1'b0, bus_wdata[31:12]};

`ifdef TERM_PORT_CTRLCHAR_EN
  assign is_ctl = (bus_wdata[7:0] == CH_LF) || (bus_wdata[7:0] == CH_CR);
`else
  assign is_ctl = 1'b0;
`endif

  term_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .cursor       (cursor),
    .load_val     (bus_wdata[11:0]),
    .advance      (cur_advance),
    .row_start    (cur_row_start),
    .next_row     (cur_next_row),
    .load_clamped (cur_load)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state decode and all port outputs, purely from the current state
  always_comb begin
    state_d    = state;
    bus_ready  = 1'b0;
    bus_rdata  = 32'd0;
    text_write = 1'b0;
    text_addr  = 12'd0;
    text_in    = 8'd0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus_req) begin
          if (bus_addr == ADDR_DATA)                          state_d = bus_we ? WR : RD_ADDR;
          else if (bus_addr == ADDR_CTRL && bus_we && bus_wdata[0]) state_d = CLEAR;
          else                                                state_d = DONE;
        end
      end
      WR: begin
        text_write = !ctl_q;
        text_addr  = cursor;
        text_in    = wdata_q;
        state_d    = DONE;
      end
      RD_ADDR: begin
        text_addr = cursor;
        state_d   = RD_DATA;
      end
      RD_DATA: state_d = DONE;
      CLEAR: begin
        text_write = 1'b1;
        text_addr  = clr_cnt;
        text_in    = CH_BLANK;
        if (clr_cnt == CELLS_M1) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b0;
        bus_ready = 1'b1;
        bus_rdata = rdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the access, update the cursor, sweep the clear counter, capture read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor  <= 12'd0;
      clr_cnt <= 12'd0;
      wdata_q <= 8'd0;
      ctl_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_req) begin
            wdata_q <= bus_wdata[7:0];
            ctl_q   <= is_ctl;
            clr_cnt <= 12'd0;
            rdata_q <= 32'd0;
            if (bus_we && bus_addr == ADDR_CURSOR) cursor <= cur_load;
            if (!bus_we) begin
              case (bus_addr)
                ADDR_CURSOR: rdata_q <= {20'd0, cursor};
                ADDR_STATUS: rdata_q <= {31'd0, busy};
                default:     rdata_q <= 32'd0;
              endcase
            end
          end
        end
        WR: begin
          if (ctl_q && wdata_q == CH_LF) cursor <= cur_next_row;
          else if (ctl_q)                cursor <= cur_row_start;
          else                           cursor <= cur_advance;
        end
        RD_DATA: rdata_q <= {24'd0, text_out};
        CLEAR: begin
          if (clr_cnt == CELLS_M1) cursor  <= 12'd0;
          else                     clr_cnt <= clr_cnt + 12'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_term_bus_port.sv
// tb/tb_term_bus_port.sv - scoreboard bench for term_bus_port with a behavioural text RAM
module tb_term_bus_port;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bus_req = 1'b0;
  logic        bus_we = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [11:0] text_addr;
  logic        text_write;
  logic [7:0]  text_in;
  logic [7:0]  text_out = 8'd0;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [19:0] wexp_q[$];

  logic [7:0] mem [0:4095];

  term_bus_port dut (
    .clk(clk), .rst(rst), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .text_addr(text_addr), .text_write(text_write), .text_in(text_in), .text_out(text_out)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (text_write) mem[text_addr] <= text_in;
    text_out <= mem[text_addr];
  end

  always @(negedge clk) begin
    logic [31:0] e;
    string n;
    if (bus_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready rdata=%h", bus_rdata);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus_rdata !== e) begin
          errors++;
          $display("FAIL %s rdata got %h want %h", n, bus_rdata, e);
        end
      end
    end else begin
      checks++;
      if (bus_rdata !== 32'd0) begin
        errors++;
        $display("FAIL rdata_idle got %h want 0", bus_rdata);
      end
    end
  end

  always @(negedge clk) begin
    logic [19:0] w;
    if (!rst && text_write) begin
      wr_count++;
      checks++;
      if (wexp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", text_addr, text_in);
      end else begin
        w = wexp_q.pop_front();
        if ({text_addr, text_in} !== w) begin
          errors++;
          $display("FAIL text_write got addr=%0d data=%h want addr=%0d data=%h",
                   text_addr, text_in, w[19:8], w[7:0]);
        end
      end
    end
  end

  task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input int exp_lat, input bit chk_busy,
                          input string name);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    exp_q.push_back(exp_rd);
    name_q.push_back(name);
    @(negedge clk);
    bus_req = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    do begin
      @(posedge clk); #1; n++;
      if (chk_busy && !bus_ready && dut.busy !== 1'b1) busy_ok = 1'b0;
    end while (!bus_ready && n < 5000);
    checks++;
    if (!bus_ready || n != exp_lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, n, exp_lat);
    end
    if (chk_busy) begin
      checks++;
      if (!busy_ok) begin
        errors++;
        $display("FAIL %s busy got 0 want 1", name);
      end
    end
    @(negedge clk);
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'd0;
  endtask

  task automatic set_cursor(input logic [31:0] v, input string name);
    bus_xfer(1'b1, 4'h4, v, 32'd0, 1, 1'b0, name);
  endtask

  task automatic read_cursor(input logic [31:0] want, input string name);
    bus_xfer(1'b0, 4'h4, 32'd0, want, 1, 1'b0, name);
  endtask

  task automatic put_char(input logic [11:0] a, input logic [7:0] c, input string name);
    wexp_q.push_back({a, c});
    bus_xfer(1'b1, 4'h0, {24'hABCDEF, c}, 32'd0, 2, 1'b0, name);
  endtask

  task automatic get_char(input logic [7:0] want, input string name);
    bus_xfer(1'b0, 4'h0, 32'd0, {24'd0, want}, 3, 1'b0, name);
  endtask

  task automatic chk1(input logic got, input logic want, input string name);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_ready, bus_rdata, text_write, text_addr, text_in} !== 54'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {bus_ready, bus_rdata, text_write, text_addr, text_in});
    end
    rst = 1'b0;

    read_cursor(32'd0, "reset_cursor");
    put_char(12'd0, 8'h41, "write_41");
    read_cursor(32'd1, "cursor_after_41");

    set_cursor(32'd2399, "cursor_2399");
    put_char(12'd2399, 8'h42, "write_42_last");
    read_cursor(32'd0, "cursor_wrap");
    set_cursor(32'd2399, "cursor_2399b");
    get_char(8'h42, "read_cell_2399");
    read_cursor(32'd2399, "cursor_after_read_last");
    set_cursor(32'd3000, "cursor_3000");
    read_cursor(32'd0, "cursor_3000_clamped");
    set_cursor(32'd2400, "cursor_2400");
    read_cursor(32'd0, "cursor_2400_clamped");
    set_cursor(32'hFFFF_F4D2, "cursor_1234_hibits");
    read_cursor(32'd1234, "cursor_1234");

    set_cursor(32'd5, "cursor_5");
    put_char(12'd5, 8'h5A, "write_5a");
    set_cursor(32'd5, "cursor_5b");
    get_char(8'h5A, "read_5a");
    read_cursor(32'd5, "cursor_after_read");

    bus_xfer(1'b0, 4'h1, 32'd0, 32'd0, 1, 1'b0, "unmapped_read");
    bus_xfer(1'b1, 4'h3, 32'd77, 32'd0, 1, 1'b0, "unmapped_write");
    bus_xfer(1'b0, 4'hC, 32'd0, 32'd0, 1, 1'b0, "status_idle");
    bus_xfer(1'b1, 4'h8, 32'd0, 32'd0, 1, 1'b0, "ctrl_write_0");
    bus_xfer(1'b0, 4'h8, 32'd0, 32'd0, 1, 1'b0, "ctrl_read");
    read_cursor(32'd5, "cursor_untouched");

`ifdef TERM_PORT_CTRLCHAR_EN
    set_cursor(32'd85, "cursor_85");
    bus_xfer(1'b1, 4'h0, 32'h0A, 32'd0, 2, 1'b0, "lf");
    read_cursor(32'd160, "cursor_after_lf");
    set_cursor(32'd170, "cursor_170");
    bus_xfer(1'b1, 4'h0, 32'h0D, 32'd0, 2, 1'b0, "cr");
    read_cursor(32'd160, "cursor_after_cr");
    set_cursor(32'd2350, "cursor_2350");
    bus_xfer(1'b1, 4'h0, 32'h0A, 32'd0, 2, 1'b0, "lf_last_row");
    read_cursor(32'd0, "cursor_lf_wrap");
`else
    set_cursor(32'd85, "cursor_85");
    put_char(12'd85, 8'h0A, "lf_stored");
    read_cursor(32'd86, "cursor_after_lf");
    set_cursor(32'd170, "cursor_170");
    put_char(12'd170, 8'h0D, "cr_stored");
    read_cursor(32'd171, "cursor_after_cr");
`endif

    for (int i = 0; i < 2400; i++) wexp_q.push_back({12'(i), 8'h20});
    bus_xfer(1'b1, 4'h8, 32'd1, 32'd0, 2401, 1'b1, "clear");
    read_cursor(32'd0, "cursor_after_clear");
    set_cursor(32'd5, "cursor_5c");
    get_char(8'h20, "cell5_blank");

    set_cursor(32'd200, "cursor_200");
    put_char(12'd200, 8'h33, "write_33");
    set_cursor(32'd150, "cursor_150");
    put_char(12'd150, 8'h44, "write_44");

    wr_count = 0;
    for (int i = 0; i < 2400; i++) wexp_q.push_back({12'(i), 8'h20});
    @(negedge clk);
    bus_req = 1'b1; bus_we = 1'b1; bus_addr = 4'h8; bus_wdata = 32'd1;
    guard = 0;
    while (wr_count < 100 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (wr_count < 100) begin
      errors++;
      $display("FAIL abort_clear_start writes got %0d want 100", wr_count);
    end
    #1;
    rst = 1'b1;
    wexp_q.delete();
    #1;
    chk1(text_write, 1'b0, "abort_text_write");
    chk1(bus_ready, 1'b0, "abort_bus_ready");
    bus_req = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    read_cursor(32'd0, "cursor_after_abort");
    set_cursor(32'd200, "cursor_200b");
    get_char(8'h33, "cell200_kept");
    set_cursor(32'd150, "cursor_150b");
    get_char(8'h44, "cell150_kept");
    set_cursor(32'd50, "cursor_50");
    get_char(8'h20, "cell50_blank");

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || wexp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect got %0d/%0d want 0/0", exp_q.size(), wexp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
